// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
// Grants the shared serial bus to one master at a time and sequences split
// reads: on a split the bus is released, other masters are served, and the
// original master gets the bus back with split_grant once the slave is ready.
// Optional feature: define ARB_RR_EN for round-robin winner selection;
// without it, arbitration is fixed priority with master 0 highest.
// All outputs are registered decodes of the FSM state, so they trail the
// internal state by one clock.

module serial_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDW         = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] mreq,
  input  logic                   ssplit,
  output logic [NUM_MASTERS-1:0] mgrant,
  output logic [IDW-1:0]         gnt_id,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic                   split_grant,
  output logic                   bus_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         split_owner_q, split_owner_d;
  logic                   split_pending_q, split_pending_d;

  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [IDW-1:0]         winner;
  logic                   win_valid;
  logic                   owner_req;
  logic                   split_owner_req;

  logic [NUM_MASTERS-1:0] mgrant_d;
  logic [IDW-1:0]         gnt_id_d;
  logic [NUM_MASTERS-1:0] msplit_d;
  logic                   split_grant_d;
  logic                   bus_busy_d;

  // Index to one-hot over the master range; out-of-range indices map to zero.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (IDW'(k) == idx) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Split-suspended master is masked out of normal arbitration.
  always_comb begin
    split_mask      = split_pending_q ? onehot(split_owner_q) : '0;
    eligible        = mreq & ~split_mask;
    owner_req       = |(mreq & onehot(owner_q));
    split_owner_req = |(mreq & onehot(split_owner_q));
  end

`ifdef ARB_RR_EN
  logic [IDW-1:0] last_q;

  // Round-robin search starting one past the last GRANT winner.
  always_comb begin
    int unsigned idx;
    win_valid = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_MASTERS;
      if (!win_valid && eligible[idx]) begin
        win_valid = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  // Pointer advances only on entry to GRANT; a RESUME leaves it untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= IDW'(NUM_MASTERS - 1);
    end else if (state_q == IDLE && state_d == GRANT) begin
      last_q <= winner;
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (!win_valid && eligible[k]) begin
        win_valid = 1'b1;
        winner    = IDW'(k);
      end
    end
  end
`endif

  // FSM state and split bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      split_owner_q   <= '0;
      split_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      split_owner_q   <= split_owner_d;
      split_pending_q <= split_pending_d;
    end
  end

  // Next-state logic; in GRANT a release is checked before a split so that
  // a simultaneous drop and split rise records no split.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    split_owner_d   = split_owner_q;
    split_pending_d = split_pending_q;
    unique case (state_q)
      IDLE: begin
        if (split_pending_q && !ssplit) begin
          state_d = RESUME;
          owner_d = split_owner_q;
        end else if (win_valid) begin
          state_d = GRANT;
          owner_d = winner;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (ssplit && !split_pending_q) begin
          split_pending_d = 1'b1;
          split_owner_d   = owner_q;
          state_d         = IDLE;
        end
      end
      RESUME: begin
        if (!split_owner_req) begin
          split_pending_d = 1'b0;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state, registered below.
  always_comb begin
    mgrant_d      = '0;
    gnt_id_d      = '0;
    msplit_d      = '0;
    split_grant_d = 1'b0;
    if (state_q == GRANT || state_q == RESUME) begin
      mgrant_d = onehot(owner_q);
      gnt_id_d = owner_q;
    end
    if (split_pending_q && state_q != RESUME) begin
      msplit_d = onehot(split_owner_q);
    end
    if (state_q == RESUME) begin
      split_grant_d = 1'b1;
    end
    bus_busy_d = |mgrant_d;
  end

  // Output registers; reset clears the grant asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mgrant      <= '0;
      gnt_id      <= '0;
      msplit      <= '0;
      split_grant <= 1'b0;
      bus_busy    <= 1'b0;
    end else begin
      mgrant      <= mgrant_d;
      gnt_id      <= gnt_id_d;
      msplit      <= msplit_d;
      split_grant <= split_grant_d;
      bus_busy    <= bus_busy_d;
    end
  end

endmodule
